univ_shift_reg_burst: RTL and testbench

//  Parametrised universal shift register. Supports per-cycle hold, load, shift,

---
 rtl/univ_shift_reg_burst.sv | 118 +++++++++++
 tb/tb_univ_shift_reg_burst.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg_burst.sv
// Universal shift register with per-cycle modes and a counted burst mode.
// A burst latches one shift-type op and repeats it 1..2**CNT_W-1 times, then pulses done.
module univ_shift_reg_burst #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] dout,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;

    function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] d,
                                                  input logic [WIDTH-1:0] ld,
                                                  input logic s);
        logic [WIDTH-1:0] r;
        case (op)
            M_LOAD:  r = ld;
            M_SHL:   r = {d[WIDTH-2:0], s};
            M_SHR:   r = {s, d[WIDTH-1:1]};
            M_ROL:   r = {d[WIDTH-2:0], d[WIDTH-1]};
            M_ROR:   r = {d[0], d[WIDTH-1:1]};
            M_ASR:   r = {d[WIDTH-1], d[WIDTH-1:1]};
            M_CLR:   r = '0;
            default: r = d;
        endcase
        return r;
    endfunction

    // Only the shift/rotate family (SHL..ASR) may be run as a burst.
    function automatic logic is_burst_op(input logic [2:0] op);
        return (op >= M_SHL) && (op <= M_ASR);
    endfunction

    always_comb begin
        state_d = state;
        op_d    = op_q;
        rem_d   = rem_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (start && is_burst_op(mode)) begin
                    op_d = mode;
                    if (cnt != '0) begin
                        data_d = apply_op(mode, data_q, din, sin);
                        rem_d  = cnt - CNT_W'(1);
                        if (cnt > CNT_W'(1)) state_d = RUN;
                        else                 done_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    data_d = apply_op(mode, data_q, din, sin);
                end
            end
            RUN: begin
                // Inputs other than sin are ignored until the burst drains.
                data_d = apply_op(op_q, data_q, din, sin);
                rem_d  = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= M_HOLD;
            rem_q  <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            op_q   <= op_d;
            rem_q  <= rem_d;
            data_q <= data_d;
            done_q <= done_d;
        end
    end

    assign dout   = data_q;
    assign sout_l = data_q[WIDTH-1];
    assign sout_r = data_q[0];
    assign busy   = (state == RUN);
    assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg_burst.sv
// Bench for univ_shift_reg_burst: directed scenarios plus random traffic against
// an arithmetic reference model (WIDTH=8, CNT_W=4).
module tb_univ_shift_reg_burst;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] mode;
    logic [7:0] din;
    logic       sin;
    logic       start;
    logic [3:0] cnt;
    logic [7:0] dout;
    logic       sout_l, sout_r, busy, done;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    logic [7:0] m_d;
    logic [2:0] m_op;
    int         m_left;
    logic       m_done;

    univ_shift_reg_burst #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .din(din), .sin(sin),
        .start(start), .cnt(cnt), .dout(dout), .sout_l(sout_l),
        .sout_r(sout_r), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] d,
                                          input logic [7:0] ld, input logic s);
        int v;
        v = int'(d);
        case (op)
            3'd1: v = int'(ld);
            3'd2: v = (v * 2 + int'(s)) % 256;
            3'd3: v = v / 2 + (s ? 128 : 0);
            3'd4: v = (v * 2) % 256 + v / 128;
            3'd5: v = v / 2 + (v % 2) * 128;
            3'd6: v = v / 2 + (v >= 128 ? 128 : 0);
            3'd7: v = 0;
            default: ;
        endcase
        return v[7:0];
    endfunction

    task automatic model_reset();
        m_d = 8'h00; m_op = 3'd0; m_left = 0; m_done = 1'b0;
    endtask

    // One clock edge of the reference behaviour, using the inputs present at the edge.
    task automatic model_edge();
        m_done = 1'b0;
        if (m_left > 0) begin
            m_d = ref_op(m_op, m_d, din, sin);
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (start && mode >= 3'd2 && mode <= 3'd6) begin
            m_op = mode;
            if (cnt == 0) begin
                m_done = 1'b1;
            end else begin
                m_d = ref_op(mode, m_d, din, sin);
                m_left = int'(cnt) - 1;
                if (m_left == 0) m_done = 1'b1;
            end
        end else begin
            m_d = ref_op(mode, m_d, din, sin);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".dout"},   32'(dout),   32'(m_d));
        check({tag, ".busy"},   32'(busy),   32'(m_left > 0));
        check({tag, ".done"},   32'(done),   32'(m_done));
        check({tag, ".sout_l"}, 32'(sout_l), 32'(m_d[7]));
        check({tag, ".sout_r"}, 32'(sout_r), 32'(m_d[0]));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic drive(input logic [2:0] md, input logic st, input logic [3:0] c,
                         input logic [7:0] d, input logic s);
        mode = md; start = st; cnt = c; din = d; sin = s;
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare_all(tag);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(3'd0, 1'b0, 4'd0, 8'h00, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        rst_n = 1'b1;

        // 1: LOAD A5, ROL, ROR
        drive(3'd1, 0, 0, 8'hA5, 0); step("t1.load");
        drive(3'd4, 0, 0, 8'h00, 0); step("t1.rol");
        check("t1.rol_const", 32'(dout), 32'h4B);
        drive(3'd5, 0, 0, 8'h00, 0); step("t1.ror");
        check("t1.ror_const", 32'(dout), 32'hA5);

        // 2: LOAD 96, ASR, SHR, CLR
        drive(3'd1, 0, 0, 8'h96, 0); step("t2.load");
        drive(3'd6, 0, 0, 8'h00, 0); step("t2.asr");
        check("t2.asr_const", 32'(dout), 32'hCB);
        drive(3'd3, 0, 0, 8'h00, 0); step("t2.shr");
        check("t2.shr_const", 32'(dout), 32'h65);
        drive(3'd7, 0, 0, 8'h00, 0); step("t2.clr");
        check("t2.clr_const", 32'({dout, sout_l, sout_r}), 32'h0);

        // 3: burst ROL x4 from 81
        drive(3'd1, 0, 0, 8'h81, 0); step("t3.load");
        drive(3'd4, 1, 4, 8'h00, 0); step("t3.b1");
        check("t3.b1_const", 32'({busy, dout}), 32'h103);
        drive(3'd0, 0, 0, 8'h00, 0);
        step("t3.b2"); step("t3.b3"); step("t3.b4");
        check("t3.final_const", 32'({busy, done, dout}), 32'h118);
        step("t3.after");
        check("t3.done_drop", 32'(done), 32'h0);

        // 4: zero-length burst
        drive(3'd1, 0, 0, 8'h3C, 0); step("t4.load");
        drive(3'd2, 1, 0, 8'h00, 1); step("t4.start0");
        check("t4.const", 32'({busy, done, dout}), 32'h13C);
        drive(3'd0, 0, 0, 8'h00, 0); step("t4.after");

        // 5: SHL x3 with sin=1, LOAD/start ignored while busy
        drive(3'd7, 0, 0, 8'h00, 0); step("t5.clr");
        drive(3'd2, 1, 3, 8'h00, 1); step("t5.b1");
        drive(3'd1, 1, 9, 8'hFF, 1); step("t5.b2");
        drive(3'd1, 0, 9, 8'hFF, 1); step("t5.b3");
        check("t5.final_const", 32'({done, dout}), 32'h107);
        drive(3'd0, 0, 0, 8'h00, 0); step("t5.after");
        check("t5.single_done", 32'(done), 32'h0);

        // 6: reset mid-burst
        drive(3'd1, 0, 0, 8'hA5, 0); step("t6.load");
        drive(3'd5, 1, 15, 8'h00, 0); step("t6.b1");
        drive(3'd0, 0, 0, 8'h00, 0);
        repeat (4) step("t6.bn");
        async_reset("t6.rst");
        check("t6.rst_const", 32'({busy, done, dout}), 32'h0);
        step("t6.hold");
        check("t6.hold_const", 32'(dout), 32'h0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            drive(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                  4'($urandom_range(0, 15)), 8'($urandom), 1'($urandom));
            step("rnd");
            if ($urandom_range(0, 99) == 0) async_reset("rnd.rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
